// File: rtl/bsg_wormhole_concentrator.sv
// Packet-atomic N:1 wormhole concentrator. Each input is buffered in a
// 2-entry FIFO, whole packets are arbitrated round-robin, and a saturating
// counter per input tallies the packets it has fully forwarded.
module bsg_wormhole_concentrator #(
  parameter int unsigned flit_width_p  = 32,
  parameter int unsigned num_in_p      = 4,
  parameter int unsigned cord_width_p  = 8,
  parameter int unsigned len_width_p   = 4,
  parameter int unsigned count_width_p = 16,
  localparam int unsigned link_width_lp = flit_width_p + 2
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_in_p*link_width_lp-1:0] links_i,
  output logic [num_in_p*link_width_lp-1:0] links_o,
  input  logic [link_width_lp-1:0]          out_link_i,
  output logic [link_width_lp-1:0]          out_link_o,
  input  logic                              clear_i,
  output logic [num_in_p*count_width_p-1:0] packet_count_o
);

  localparam int unsigned sel_width_lp = $clog2(num_in_p);
  localparam logic [sel_width_lp:0] num_in_lp = (sel_width_lp+1)'(num_in_p);
  localparam logic [sel_width_lp-1:0] last_in_lp = sel_width_lp'(num_in_p - 1);

  localparam logic state_idle = 1'b0;
  localparam logic state_busy = 1'b1;

  logic [flit_width_p-1:0]  mem_q [num_in_p][2];
  logic [num_in_p-1:0]      wr_ptr_q, rd_ptr_q;
  logic [1:0]               fill_q [num_in_p];
  logic [count_width_p-1:0] count_q [num_in_p];

  logic                     state_q, state_d;
  logic [sel_width_lp-1:0]  last_grant_q, last_grant_d;
  logic [sel_width_lp-1:0]  owner_q, owner_d;
  logic [len_width_p-1:0]   remaining_q, remaining_d;

  logic [num_in_p-1:0]      in_v, enq, deq, full, nonempty;
  logic [flit_width_p-1:0]  in_data [num_in_p];
  logic [flit_width_p-1:0]  head [num_in_p];
  logic [sel_width_lp-1:0]  grant, sel;
  logic [sel_width_lp:0]    scan;
  logic                     out_v, out_ready, hs, done;
  logic [len_width_p-1:0]   hdr_len;
  logic                     unused_link_bits;

  // Unpack input links, derive FIFO status and drive the per-input ready
  always_comb begin
    links_o = '0;
    unused_link_bits = out_link_i[flit_width_p+1] ^ (^out_link_i[flit_width_p-1:0]);
    for (int i = 0; i < num_in_p; i++) begin
      in_v[i]     = links_i[i*link_width_lp + flit_width_p + 1];
      in_data[i]  = links_i[i*link_width_lp +: flit_width_p];
      full[i]     = (fill_q[i] == 2'd2);
      nonempty[i] = (fill_q[i] != 2'd0);
      enq[i]      = in_v[i] & ~full[i];
      head[i]     = mem_q[i][rd_ptr_q[i]];
      links_o[i*link_width_lp + flit_width_p] = ~full[i];
      unused_link_bits = unused_link_bits ^ links_i[i*link_width_lp + flit_width_p];
    end
  end

  // Round-robin pick: first non-empty input after last_grant, wrapping
  always_comb begin
    grant = '0;
    scan  = '0;
    // Walk downward so the nearest candidate is the last one written
    for (int k = num_in_p; k >= 1; k--) begin
      scan = {1'b0, last_grant_q} + (sel_width_lp+1)'(k);
      if (scan >= num_in_lp) scan = scan - num_in_lp;
      if (nonempty[scan[sel_width_lp-1:0]]) grant = scan[sel_width_lp-1:0];
    end
  end

  // Output mux and handshake; only the selected FIFO is ever dequeued
  always_comb begin
    sel        = (state_q == state_busy) ? owner_q : grant;
    out_v      = (state_q == state_busy) ? nonempty[owner_q] : (|nonempty);
    out_ready  = out_link_i[flit_width_p];
    hs         = out_v & out_ready;
    hdr_len    = head[sel][cord_width_p +: len_width_p];
    out_link_o = {out_v, 1'b0, head[sel]};
    deq        = '0;
    if (hs) deq[sel] = 1'b1;
  end

  // Packet FSM: a header locks the owner until its body has drained
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    remaining_d  = remaining_q;
    last_grant_d = last_grant_q;
    done         = 1'b0;
    if (hs) begin
      if (state_q == state_idle) begin
        if (hdr_len == '0) begin
          done         = 1'b1;
          last_grant_d = grant;
        end else begin
          state_d     = state_busy;
          owner_d     = grant;
          remaining_d = hdr_len;
        end
      end else begin
        remaining_d = remaining_q - len_width_p'(1);
        if (remaining_q == len_width_p'(1)) begin
          state_d      = state_idle;
          last_grant_d = owner_q;
          done         = 1'b1;
        end
      end
    end
  end

  // Per-input 2-entry FIFOs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < num_in_p; i++) fill_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < num_in_p; i++) begin
        if (enq[i]) begin
          mem_q[i][wr_ptr_q[i]] <= in_data[i];
          wr_ptr_q[i]           <= ~wr_ptr_q[i];
        end
        if (deq[i]) rd_ptr_q[i] <= ~rd_ptr_q[i];
        fill_q[i] <= fill_q[i] + 2'(enq[i]) - 2'(deq[i]);
      end
    end
  end

  // FSM and arbitration state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= state_idle;
      last_grant_q <= last_in_lp;
      owner_q      <= '0;
      remaining_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      remaining_q  <= remaining_d;
    end
  end

  // Saturating packet counters; clear overrides a coincident completion
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      for (int i = 0; i < num_in_p; i++) count_q[i] <= '0;
    end else if (done && (count_q[sel] != '1)) begin
      count_q[sel] <= count_q[sel] + count_width_p'(1);
    end
  end

  // Flatten counters onto the output bus
  always_comb begin
    packet_count_o = '0;
    for (int i = 0; i < num_in_p; i++) begin
      packet_count_o[i*count_width_p +: count_width_p] = count_q[i];
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_concentrator.sv
// Bench for bsg_wormhole_concentrator: directed scenarios plus random traffic,
// checked by a packet-level scoreboard and a FIFO occupancy model.
module tb_bsg_wormhole_concentrator;
  localparam int F  = 32;
  localparam int N  = 4;
  localparam int LW = F + 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, clear, out_ready;
  logic [N-1:0]      in_v;
  logic [F-1:0]      in_data [N];
  logic [N*LW-1:0]   links_i, links_o;
  logic [LW-1:0]     out_link_i, out_link_o;
  logic [N*CW-1:0]   pcount;
  logic [N-1:0]      rdy;
  logic              out_v;
  logic [F-1:0]      out_data;

  // Second instance with 2-bit counters to reach saturation quickly
  logic              s_v, s_clear;
  logic [F-1:0]      s_data;
  logic [N*LW-1:0]   s_links_i, s_links_o;
  logic [LW-1:0]     s_out_link_i, s_out_link_o;
  logic [N*2-1:0]    s_pcount;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      links_i[i*LW +: LW] = {in_v[i], 1'b0, in_data[i]};
      rdy[i] = links_o[i*LW + F];
    end
    out_link_i   = {1'b0, out_ready, {F{1'b0}}};
    out_v        = out_link_o[F+1];
    out_data     = out_link_o[F-1:0];
    s_links_i    = '0;
    s_links_i[LW-1:0] = {s_v, 1'b0, s_data};
    s_out_link_i = {1'b0, 1'b1, {F{1'b0}}};
  end

  bsg_wormhole_concentrator dut (
    .clk_i(clk), .reset_i(reset), .links_i(links_i), .links_o(links_o),
    .out_link_i(out_link_i), .out_link_o(out_link_o), .clear_i(clear),
    .packet_count_o(pcount)
  );

  bsg_wormhole_concentrator #(.count_width_p(2)) dut_small (
    .clk_i(clk), .reset_i(reset), .links_i(s_links_i), .links_o(s_links_o),
    .out_link_i(s_out_link_i), .out_link_o(s_out_link_o), .clear_i(s_clear),
    .packet_count_o(s_pcount)
  );

  typedef struct {logic [31:0] d; int c;} ent_t;

  int          n_assert = 0, n_fail = 0;
  int          cyc = 0;
  int          seq_ctr = 0;
  logic [31:0] exp_q [N][$];
  int          model_cnt [N];
  int          enq_cnt [N], deq_cnt [N];
  ent_t        log_q [$];
  bit          in_pkt, prev_hold;
  int          cur_src, cur_rem;
  logic [31:0] prev_data;
  int          threads_done;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flit: [31:28] source, [27:16] seq, [15:12] index in packet, [11:8] len, [7:0] cord
  function automatic logic [31:0] mk_flit(input int p, input int s, input int k, input int len);
    return {p[3:0], s[11:0], k[3:0], len[3:0], s[7:0]};
  endfunction

  function automatic logic [63:0] pack_model();
    logic [63:0] r = '0;
    for (int i = 0; i < N; i++) r[i*CW +: CW] = 16'(model_cnt[i]);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle observer: ready vs buffered occupancy, hold under backpressure,
  // and packet-atomic ordering against the queues of sent flits.
  task automatic monitor_step();
    logic [31:0] d, e;
    int src, want;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        exp_q[i].delete();
        enq_cnt[i] = 0; deq_cnt[i] = 0; model_cnt[i] = 0;
      end
      in_pkt = 0; prev_hold = 0;
      return;
    end
    if (clear) for (int i = 0; i < N; i++) model_cnt[i] = 0;
    for (int i = 0; i < N; i++) begin
      check("in_ready", 64'(rdy[i]), 64'((enq_cnt[i] - deq_cnt[i]) < 2));
      if (in_v[i] && rdy[i]) enq_cnt[i]++;
    end
    if (prev_hold) begin
      check("hold_v", 64'(out_v), 64'(1));
      check("hold_data", 64'(out_data), 64'(prev_data));
    end
    prev_hold = out_v && !out_ready;
    prev_data = out_data;
    if (out_v && out_ready) begin
      d = out_data;
      src = int'(d[31:28]);
      log_q.push_back('{d: d, c: cyc});
      want = in_pkt ? cur_src : src;
      if (want >= N) begin
        check("sb_source", 64'(src), 64'(0));
      end else begin
        deq_cnt[want]++;
        if (exp_q[want].size() == 0) begin
          check("sb_spurious", 64'(d), 64'(0));
        end else begin
          e = exp_q[want].pop_front();
          check("sb_flit", 64'(d), 64'(e));
        end
      end
      if (!in_pkt) begin
        if (d[11:8] != 4'd0) begin
          in_pkt = 1; cur_src = want; cur_rem = int'(d[11:8]);
        end
      end else begin
        cur_rem--;
        if (cur_rem == 0) in_pkt = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  task automatic push_flit(input int p, input logic [31:0] d);
    bit ok;
    int guard = 0;
    in_v[p] = 1'b1;
    in_data[p] = d;
    do begin
      @(negedge clk);
      ok = rdy[p];
      if (ok) exp_q[p].push_back(d);
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 300);
    if (!ok) check("push_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_pkt(input int p, input int len);
    int s = seq_ctr++;
    for (int k = 0; k <= len; k++) push_flit(p, mk_flit(p, s, k, len));
    in_v[p] = 1'b0;
    model_cnt[p]++;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
           && g < 600) begin
      tick(1);
      g++;
    end
    if (g >= 600) check("drain_timeout", 64'(0), 64'(1));
    tick(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic fair_thread(input int p, input int stop);
    while (cyc < stop) begin
      push_flit(p, mk_flit(p, seq_ctr++, 0, 0));
      model_cnt[p]++;
    end
    in_v[p] = 1'b0;
  endtask

  task automatic rand_thread(input int p);
    repeat (12) begin
      tick($urandom_range(0, 3));
      send_pkt(p, $urandom_range(0, 5));
    end
    threads_done++;
  endtask

  initial begin
    int t0, s, c;
    int cnt [N];
    bit saw_low;
    reset = 1'b1; clear = 1'b0; out_ready = 1'b1; in_v = '0;
    s_v = 1'b0; s_clear = 1'b0; s_data = '0;
    for (int i = 0; i < N; i++) in_data[i] = '0;
    tick(2);
    // Reset values are also visible while reset is still asserted
    check("rst_out_v", 64'(out_v), 64'(0));
    check("rst_ready", 64'(rdy), 64'(4'hf));
    reset = 1'b0;
    tick(1);
    check("rst_count", 64'(pcount), 64'(0));
    check("rst_idle_v", 64'(out_v), 64'(0));

    // Single packet from input 2, back to back
    log_q.delete();
    t0 = cyc;
    send_pkt(2, 3);
    drain();
    check("single_len", 64'(log_q.size()), 64'(4));
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      check("single_src", 64'(log_q[k].d[31:28]), 64'(2));
      check("single_idx", 64'(log_q[k].d[15:12]), 64'(k));
      check("single_cycle", 64'(log_q[k].c), 64'(t0 + 1 + k));
    end
    check("single_cnt", 64'(pcount), 64'h0000_0001_0000_0000);

    // Contention: inputs 0 and 1 present together after reset
    do_reset();
    log_q.delete();
    fork
      send_pkt(0, 2);
      send_pkt(1, 2);
    join
    drain();
    check("cont_len", 64'(log_q.size()), 64'(6));
    for (int k = 0; k < 6 && k < log_q.size(); k++)
      check("cont_src", 64'(log_q[k].d[31:28]), 64'(k < 3 ? 0 : 1));
    // With last_grant at 1 the scan starts at 2, so input 0 wins again
    fork
      send_pkt(0, 0);
      send_pkt(1, 0);
    join
    drain();
    check("cont_rr_len", 64'(log_q.size()), 64'(8));
    if (log_q.size() >= 8) begin
      check("cont_rr_first", 64'(log_q[6].d[31:28]), 64'(0));
      check("cont_rr_second", 64'(log_q[7].d[31:28]), 64'(1));
    end
    check("cont_cnt", 64'(pcount), pack_model());

    // Fairness: four inputs streaming zero-length packets
    do_reset();
    log_q.delete();
    t0 = cyc;
    fork
      fair_thread(0, t0 + 40);
      fair_thread(1, t0 + 40);
      fair_thread(2, t0 + 40);
      fair_thread(3, t0 + 40);
    join
    drain();
    check("fair_enough", 64'(log_q.size() >= 40), 64'(1));
    if (log_q.size() >= 40) begin
      check("fair_first", 64'(log_q[0].d[31:28]), 64'(0));
      for (int k = 1; k < 36; k++)
        check("fair_order", 64'(log_q[k].d[31:28]), 64'((log_q[k-1].d[31:28] + 1) % N));
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int k = 0; k < 40; k++) cnt[log_q[k].d[29:28]]++;
      for (int i = 0; i < N; i++) check("fair_share", 64'(cnt[i] >= 9 && cnt[i] <= 11), 64'(1));
    end
    check("fair_cnt", 64'(pcount), pack_model());

    // Backpressure: output ready toggles during a len=5 packet from input 3
    do_reset();
    log_q.delete();
    saw_low = 0;
    fork
      send_pkt(3, 5);
      begin
        for (int k = 0; k < 30; k++) begin
          out_ready = (k % 2 == 0);
          tick(1);
          if (!rdy[3]) saw_low = 1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_ready_dropped", 64'(saw_low), 64'(1));
    check("bp_len", 64'(log_q.size()), 64'(6));
    for (int k = 0; k < 6 && k < log_q.size(); k++)
      check("bp_idx", 64'(log_q[k].d[15:12]), 64'(k));
    check("bp_cnt", 64'(pcount), pack_model());

    // Owner stall: input 1 pauses mid-packet while input 0 waits
    do_reset();
    log_q.delete();
    fork
      begin
        s = seq_ctr++;
        push_flit(1, mk_flit(1, s, 0, 2));
        in_v[1] = 1'b0;
        @(negedge clk);
        repeat (4) begin
          @(negedge clk);
          check("stall_v", 64'(out_v), 64'(0));
        end
        @(posedge clk);
        #1;
        push_flit(1, mk_flit(1, s, 1, 2));
        push_flit(1, mk_flit(1, s, 2, 2));
        in_v[1] = 1'b0;
        model_cnt[1]++;
      end
      begin
        tick(1);
        send_pkt(0, 1);
      end
    join
    drain();
    check("stall_len", 64'(log_q.size()), 64'(5));
    for (int k = 0; k < 5 && k < log_q.size(); k++)
      check("stall_src", 64'(log_q[k].d[31:28]), 64'(k < 3 ? 1 : 0));
    check("stall_cnt", 64'(pcount), pack_model());

    // Reset in the middle of a len=4 body
    s = seq_ctr++;
    push_flit(2, mk_flit(2, s, 0, 4));
    push_flit(2, mk_flit(2, s, 1, 4));
    push_flit(2, mk_flit(2, s, 2, 4));
    in_v[2] = 1'b0;
    do_reset();
    check("midrst_out_v", 64'(out_v), 64'(0));
    check("midrst_ready", 64'(rdy), 64'(4'hf));
    check("midrst_cnt", 64'(pcount), 64'(0));
    send_pkt(2, 4);
    drain();
    check("midrst_restart_cnt", 64'(pcount), 64'h0000_0001_0000_0000);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_main", 64'(pcount), 64'(0));

    // Saturation on the 2-bit counter instance
    c = 0;
    s_v = 1'b1;
    s_data = mk_flit(0, 0, 0, 0);
    for (int g = 0; g < 50 && c < 5; g++) begin
      @(negedge clk);
      if (s_links_o[F]) c++;
      @(posedge clk);
      #1;
    end
    s_v = 1'b0;
    tick(3);
    check("sat_count", 64'(s_pcount[1:0]), 64'(3));
    s_clear = 1'b1;
    tick(1);
    s_clear = 1'b0;
    check("sat_clear", 64'(s_pcount[1:0]), 64'(0));
    // Clear on the same edge that completes a packet leaves zero
    s_v = 1'b1;
    tick(1);
    s_v = 1'b0;
    s_clear = 1'b1;
    tick(1);
    s_clear = 1'b0;
    tick(1);
    check("clear_wins", 64'(s_pcount[1:0]), 64'(0));
    s_v = 1'b1;
    tick(1);
    s_v = 1'b0;
    tick(3);
    check("count_after_clear", 64'(s_pcount[1:0]), 64'(1));

    // Random traffic with random output backpressure
    do_reset();
    threads_done = 0;
    fork
      rand_thread(0);
      rand_thread(1);
      rand_thread(2);
      rand_thread(3);
      begin
        for (int g = 0; g < 20000 && threads_done < N; g++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick(1);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < N; i++)
      check("rand_cnt", 64'(pcount[i*CW +: CW]), 64'(model_cnt[i]));
    check("rand_idle_v", 64'(out_v), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
